// File: rtl/hpdcache_wb_pkg.sv
// hpdcache_wb_pkg
//   Shared types and geometry helpers for the HPDcache write-back eviction
//   buffer.
//   - wb_entry_t      : one queued victim line (address + data) for the
//                       default cache geometry.
//   - wb_state_e      : transmit FSM states.
//   - WB_BEATS / WB_OFFSET_WIDTH : default beat count and line-offset width.
//   - wb_num_beats / wb_offset_width : the same values for any geometry.
package hpdcache_wb_pkg;

  localparam int unsigned WB_LINE_WIDTH   = 128;
  localparam int unsigned WB_DATA_WIDTH   = 64;
  localparam int unsigned WB_ADDR_WIDTH   = 64;
  localparam int unsigned WB_BEATS        = WB_LINE_WIDTH / WB_DATA_WIDTH;
  localparam int unsigned WB_OFFSET_WIDTH = $clog2(WB_LINE_WIDTH / 8);

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_LINE_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_SEND_AW = 2'd1,
    WB_SEND_W  = 2'd2,
    WB_WAIT_B  = 2'd3
  } wb_state_e;

  // Number of W beats needed to carry one line.
  function automatic int unsigned wb_num_beats(input int unsigned line_w,
                                               input int unsigned data_w);
    return line_w / data_w;
  endfunction

  // Number of byte-offset bits inside one line.
  function automatic int unsigned wb_offset_width(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/hpdcache_wb_evict_buf_chk.sv
// hpdcache_wb_evict_buf_chk
//   Simulation-only protocol checks for the eviction buffer's AXI write port.
//   Ports: i_clk, i_rst_n, AW valid/ready/addr, B valid/ready/id.
module hpdcache_wb_evict_buf_chk #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned WbId      = 0
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  input logic                 i_aw_valid,
  input logic                 i_aw_ready,
  input logic [AddrWidth-1:0] i_aw_addr,
  input logic                 i_b_valid,
  input logic                 i_b_ready,
  input logic [IdWidth-1:0]   i_b_id
);

  // Every accepted write response must carry the eviction ID.
  a_b_id: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_b_valid && i_b_ready) |-> (i_b_id == IdWidth'(WbId)));

  // AW must hold valid and address until accepted.
  a_aw_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_aw_valid && !i_aw_ready) |=> (i_aw_valid && $stable(i_aw_addr)));

endmodule

// File: rtl/hpdcache_wb_evict_fifo.sv
// hpdcache_wb_evict_fifo
//   Small circular FIFO of victim lines that also exposes every slot's
//   address and valid bit, so the owner can snoop all held lines.
//   Ports:
//     clk_i, rst_ni       clock, synchronous active-low reset
//     i_push, i_addr, i_data   write one entry (caller guarantees !o_full)
//     i_pop               free the head entry (caller guarantees !o_empty)
//     o_full, o_empty, o_count   occupancy
//     o_head_addr, o_head_data   head entry contents
//     o_valid, o_addr     per-slot valid bit and stored address
module hpdcache_wb_evict_fifo #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineWidth = 128,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            i_push,
  input  logic [AddrWidth-1:0]            i_addr,
  input  logic [LineWidth-1:0]            i_data,
  input  logic                            i_pop,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [CntW-1:0]                 o_count,
  output logic [AddrWidth-1:0]            o_head_addr,
  output logic [LineWidth-1:0]            o_head_data,
  output logic [Depth-1:0]                o_valid,
  output logic [Depth-1:0][AddrWidth-1:0] o_addr
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0][AddrWidth-1:0] r_addr;
  logic [Depth-1:0][LineWidth-1:0] r_data;
  logic [Depth-1:0]                r_valid;
  logic [PtrW-1:0]                 r_wptr;
  logic [PtrW-1:0]                 r_rptr;
  logic [CntW-1:0]                 r_count;

  logic [PtrW-1:0] w_wptr_nxt;
  logic [PtrW-1:0] w_rptr_nxt;

  // Pointer wrap is explicit so non-power-of-two depths work.
  assign w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : r_wptr + PtrW'(1);
  assign w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : r_rptr + PtrW'(1);

  // Storage, pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= {Depth{1'b0}};
      r_wptr  <= {PtrW{1'b0}};
      r_rptr  <= {PtrW{1'b0}};
      r_count <= {CntW{1'b0}};
    end else begin
      if (i_push) begin
        r_addr[r_wptr]  <= i_addr;
        r_data[r_wptr]  <= i_data;
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= w_wptr_nxt;
      end
      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= w_rptr_nxt;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full      = (r_count == CntW'(Depth));
  assign o_empty     = (r_count == {CntW{1'b0}});
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_valid     = r_valid;
  assign o_addr      = r_addr;

endmodule

// File: rtl/hpdcache_wb_evict_buf.sv
// hpdcache_wb_evict_buf
//   Write-back eviction buffer: queues dirty victim lines and sends each one
//   as a single AXI4 INCR write burst (AW, N W beats, B). One transaction is
//   outstanding at a time. A snoop port reports whether a line is still held.
//   Ports:
//     clk_i, rst_ni                    clock, synchronous active-low reset
//     evict_valid_i/ready_o/addr_i/data_i   victim line input
//     aw_*                             AXI write address channel
//     w_*                              AXI write data channel
//     b_*                              AXI write response channel
//     snoop_addr_i / snoop_hit_o       held-line lookup (combinational)
//     busy_o                           any entry held
//     err_o                            one-cycle pulse on SLVERR/DECERR
module hpdcache_wb_evict_buf
  import hpdcache_wb_pkg::*;
#(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned WbId      = 0,
  parameter int unsigned Depth     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   evict_valid_i,
  output logic                   evict_ready_o,
  input  logic [AddrWidth-1:0]   evict_addr_i,
  input  logic [LineWidth-1:0]   evict_data_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [IdWidth-1:0]     aw_id_o,
  output logic [7:0]             aw_len_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [IdWidth-1:0]     b_id_i,
  input  logic [1:0]             b_resp_i,
  input  logic [AddrWidth-1:0]   snoop_addr_i,
  output logic                   snoop_hit_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned Beats = wb_num_beats(LineWidth, DataWidth);
  localparam int unsigned OffW  = wb_offset_width(LineWidth);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrWidth-1:0] LineMask =
    ~((AddrWidth'(1) << OffW) - AddrWidth'(1));

  wb_state_e r_state;
  logic [BeatW-1:0] r_beat;
  logic             r_err;

  logic                            w_push;
  logic                            w_full;
  logic                            w_empty;
  logic [CntW-1:0]                 w_count;
  logic [AddrWidth-1:0]            w_head_addr;
  logic [LineWidth-1:0]            w_head_data;
  logic [Depth-1:0]                w_valid;
  logic [Depth-1:0][AddrWidth-1:0] w_addr;
  logic                            w_aw_hs;
  logic                            w_w_hs;
  logic                            w_b_hs;
  logic                            w_last_beat;
  logic [AddrWidth-1:0]            w_snoop_line;
  logic                            w_snoop_hit;
  logic                            w_unused_resp;

  assign w_push      = evict_valid_i && evict_ready_o;
  assign w_aw_hs     = aw_valid_o && aw_ready_i;
  assign w_w_hs      = w_valid_o && w_ready_i;
  assign w_b_hs      = b_valid_i && b_ready_o;
  assign w_last_beat = (r_beat == BeatW'(Beats - 1));
  // Only bit 1 distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign w_unused_resp = b_resp_i[0];

  hpdcache_wb_evict_fifo #(
    .Depth     (Depth),
    .AddrWidth (AddrWidth),
    .LineWidth (LineWidth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_addr      (evict_addr_i & LineMask),
    .i_data      (evict_data_i),
    .i_pop       (w_b_hs),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_valid     (w_valid),
    .o_addr      (w_addr)
  );

  // Transmit FSM, beat counter and error pulse. An entry pushed while IDLE,
  // or still queued when B arrives, starts its AW the very next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= WB_IDLE;
      r_beat  <= {BeatW{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_err <= w_b_hs && b_resp_i[1];
      case (r_state)
        WB_IDLE: begin
          if (w_push || !w_empty) r_state <= WB_SEND_AW;
          else                    r_state <= WB_IDLE;
        end
        WB_SEND_AW: begin
          r_beat <= {BeatW{1'b0}};
          if (w_aw_hs) r_state <= WB_SEND_W;
          else         r_state <= WB_SEND_AW;
        end
        WB_SEND_W: begin
          if (w_w_hs && w_last_beat) begin
            r_beat  <= {BeatW{1'b0}};
            r_state <= WB_WAIT_B;
          end else if (w_w_hs) begin
            r_beat  <= r_beat + BeatW'(1);
          end else begin
            r_beat  <= r_beat;
          end
        end
        WB_WAIT_B: begin
          // The head is popped this cycle, so another line exists only if
          // more than one was held or one is arriving now.
          if (w_b_hs && ((w_count > CntW'(1)) || w_push)) r_state <= WB_SEND_AW;
          else if (w_b_hs)                                r_state <= WB_IDLE;
          else                                            r_state <= WB_WAIT_B;
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  // Snoop against every held slot; the in-flight head stays valid until B.
  always_comb begin
    w_snoop_line = snoop_addr_i & LineMask;
    w_snoop_hit  = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      w_snoop_hit = w_snoop_hit | (w_valid[i] && (w_addr[i] == w_snoop_line));
    end
  end

  assign evict_ready_o = !w_full;
  assign aw_valid_o    = (r_state == WB_SEND_AW);
  assign aw_addr_o     = w_head_addr;
  assign aw_id_o       = IdWidth'(WbId);
  assign aw_len_o      = 8'(Beats - 1);
  assign w_valid_o     = (r_state == WB_SEND_W);
  assign w_data_o      = w_head_data[r_beat*DataWidth +: DataWidth];
  assign w_strb_o      = {(DataWidth/8){1'b1}};
  assign w_last_o      = w_valid_o && w_last_beat;
  assign b_ready_o     = (r_state == WB_WAIT_B);
  assign snoop_hit_o   = w_snoop_hit;
  assign busy_o        = !w_empty;
  assign err_o         = r_err;

  hpdcache_wb_evict_buf_chk #(
    .AddrWidth (AddrWidth),
    .IdWidth   (IdWidth),
    .WbId      (WbId)
  ) u_chk (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_aw_valid (aw_valid_o),
    .i_aw_ready (aw_ready_i),
    .i_aw_addr  (aw_addr_o),
    .i_b_valid  (b_valid_i),
    .i_b_ready  (b_ready_o),
    .i_b_id     (b_id_i)
  );

endmodule

// File: tb/tb_hpdcache_wb_evict_buf.sv
// tb_hpdcache_wb_evict_buf
//   Directed bench for the eviction buffer. Expected AW addresses and W beats
//   are queued when a line is offered and consumed as the DUT hands them out.
module tb_hpdcache_wb_evict_buf;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         evict_valid_i;
  logic         evict_ready_o;
  logic [63:0]  evict_addr_i;
  logic [127:0] evict_data_i;
  logic         aw_valid_o;
  logic         aw_ready_i;
  logic [63:0]  aw_addr_o;
  logic [3:0]   aw_id_o;
  logic [7:0]   aw_len_o;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [63:0]  w_data_o;
  logic [7:0]   w_strb_o;
  logic         w_last_o;
  logic         b_valid_i;
  logic         b_ready_o;
  logic [3:0]   b_id_i;
  logic [1:0]   b_resp_i;
  logic [63:0]  snoop_addr_i;
  logic         snoop_hit_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;
  int w_hs   = 0;

  logic [63:0] exp_aw[$];
  logic [64:0] exp_w[$];  // {data, last}

  bit          s_acc;
  bit          s_bhs;
  bit          aw_pend = 1'b0;
  bit          w_pend  = 1'b0;
  logic [63:0] aw_prev;
  logic [63:0] w_prev;
  logic        w_last_prev;

  always #5 clk = ~clk;

  hpdcache_wb_evict_buf #(
    .LineWidth (128),
    .DataWidth (64),
    .AddrWidth (64),
    .IdWidth   (4),
    .WbId      (0),
    .Depth     (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .evict_valid_i (evict_valid_i),
    .evict_ready_o (evict_ready_o),
    .evict_addr_i  (evict_addr_i),
    .evict_data_i  (evict_data_i),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .aw_addr_o     (aw_addr_o),
    .aw_id_o       (aw_id_o),
    .aw_len_o      (aw_len_o),
    .w_valid_o     (w_valid_o),
    .w_ready_i     (w_ready_i),
    .w_data_o      (w_data_o),
    .w_strb_o      (w_strb_o),
    .w_last_o      (w_last_o),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .b_id_i        (b_id_i),
    .b_resp_i      (b_resp_i),
    .snoop_addr_i  (snoop_addr_i),
    .snoop_hit_o   (snoop_hit_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: observe handshakes on the falling edge, then return
  // just after the next rising edge.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    s_acc = evict_valid_i && evict_ready_o;
    s_bhs = b_valid_i && b_ready_o;
    if (rst_ni) begin
      if (aw_pend) begin
        chk("aw_hold_valid", aw_valid_o, 1'b1);
        chk("aw_hold_addr", aw_addr_o, aw_prev);
      end
      if (aw_valid_o && aw_ready_i) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", aw_valid_o, 1'b0);
        else begin
          chk("aw_addr", aw_addr_o, exp_aw.pop_front());
          chk("aw_len", aw_len_o, 8'd1);
          chk("aw_id", aw_id_o, 4'd0);
        end
      end
      aw_pend = aw_valid_o && !aw_ready_i;
      aw_prev = aw_addr_o;
      if (w_pend) begin
        chk("w_hold_valid", w_valid_o, 1'b1);
        chk("w_hold_data", w_data_o, w_prev);
        chk("w_hold_last", w_last_o, w_last_prev);
      end
      if (w_valid_o && w_ready_i) begin
        w_hs++;
        if (exp_w.size() == 0) chk("w_unexpected", w_valid_o, 1'b0);
        else begin
          e = exp_w.pop_front();
          chk("w_data", w_data_o, e[64:1]);
          chk("w_last", w_last_o, e[0]);
          chk("w_strb", w_strb_o, 8'hFF);
        end
      end
      w_pend      = w_valid_o && !w_ready_i;
      w_prev      = w_data_o;
      w_last_prev = w_last_o;
    end else begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic exp_line(input logic [63:0] a, input logic [127:0] d);
    exp_aw.push_back(a & 64'hFFFF_FFFF_FFFF_FFF0);
    exp_w.push_back({d[63:0], 1'b0});
    exp_w.push_back({d[127:64], 1'b1});
  endtask

  // Offer a line and wait (bounded) until it is accepted.
  task automatic do_push(input logic [63:0] a, input logic [127:0] d);
    bit ok;
    ok = 1'b0;
    exp_line(a, d);
    evict_valid_i = 1'b1;
    evict_addr_i  = a;
    evict_data_i  = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_acc) begin
        ok = 1'b1;
        break;
      end
    end
    evict_valid_i = 1'b0;
    chk("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy_o) break;
      tick();
    end
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_aw_queue", exp_aw.size(), 0);
    chk("drain_w_queue", exp_w.size(), 0);
  endtask

  task automatic wait_b();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_bhs) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b_seen", seen, 1'b1);
  endtask

  initial begin
    int ai;
    int bi;
    rst_ni        = 1'b0;
    evict_valid_i = 1'b0;
    evict_addr_i  = 64'h0;
    evict_data_i  = 128'h0;
    aw_ready_i    = 1'b1;
    w_ready_i     = 1'b1;
    b_valid_i     = 1'b1;
    b_id_i        = 4'd0;
    b_resp_i      = 2'b00;
    snoop_addr_i  = 64'h0;

    // Reset values
    tick();
    tick();
    chk("rst_evict_ready", evict_ready_o, 1'b1);
    chk("rst_aw_valid", aw_valid_o, 1'b0);
    chk("rst_w_valid", w_valid_o, 1'b0);
    chk("rst_b_ready", b_ready_o, 1'b0);
    chk("rst_snoop_hit", snoop_hit_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // Single eviction with every ready high: AW, 2 W, 1 B, then idle.
    do_push(64'h8000_1234, {64'hBBBB, 64'hAAAA});
    chk("single_aw_valid", aw_valid_o, 1'b1);
    chk("single_aw_addr", aw_addr_o, 64'h8000_1230);
    chk("single_busy", busy_o, 1'b1);
    tick();
    tick();
    tick();
    chk("single_b_ready", b_ready_o, 1'b1);
    chk("single_busy_wait_b", busy_o, 1'b1);
    tick();
    chk("single_busy_low", busy_o, 1'b0);
    chk("single_b_ready_low", b_ready_o, 1'b0);
    wait_idle();

    // Back-pressure: AW held off for 5 cycles, then W ready toggling.
    aw_ready_i = 1'b0;
    do_push(64'h8000_2000, {64'h2222_3333_4444_5555, 64'h1111_6666_7777_8888});
    for (int i = 0; i < 5; i++) tick();
    chk("bp_aw_valid", aw_valid_o, 1'b1);
    chk("bp_aw_addr", aw_addr_o, 64'h8000_2000);
    chk("bp_no_w_before_aw", w_valid_o, 1'b0);
    w_hs       = 0;
    aw_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w_ready_i = !w_ready_i;
      tick();
      if (!busy_o) break;
    end
    w_ready_i = 1'b1;
    chk("bp_w_handshakes", w_hs, 2);
    wait_idle();

    // Full: two lines held with B withheld, the third stalls.
    b_valid_i = 1'b0;
    do_push(64'h8000_3000, {64'h3001, 64'h3000});
    do_push(64'h8000_3040, {64'h3041, 64'h3040});
    exp_line(64'h8000_3080, {64'h3081, 64'h3080});
    evict_valid_i = 1'b1;
    evict_addr_i  = 64'h8000_3080;
    evict_data_i  = {64'h3081, 64'h3080};
    ai = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_acc) ai++;
    end
    chk("full_no_accept", ai, 0);
    chk("full_ready_low", evict_ready_o, 1'b0);
    b_valid_i = 1'b1;
    ai = -1;
    bi = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_bhs && bi < 0) begin
        bi = i;
        chk("full_next_aw_after_b", aw_valid_o, 1'b1);
      end
      if (s_acc) begin
        ai = i;
        break;
      end
    end
    evict_valid_i = 1'b0;
    chk("full_accept_cycle_after_b", ai, bi + 1);
    wait_idle();

    // Snoop
    b_valid_i = 1'b0;
    do_push(64'h8000_0040, {64'h4041, 64'h4040});
    snoop_addr_i = 64'h8000_004F;
    #1;
    chk("snoop_hit_offset", snoop_hit_o, 1'b1);
    snoop_addr_i = 64'h8000_0050;
    #1;
    chk("snoop_miss_next_line", snoop_hit_o, 1'b0);
    exp_line(64'h8000_0080, {64'h8081, 64'h8080});
    evict_valid_i = 1'b1;
    evict_addr_i  = 64'h8000_0080;
    evict_data_i  = {64'h8081, 64'h8080};
    snoop_addr_i  = 64'h8000_0080;
    #1;
    chk("snoop_same_cycle_push", snoop_hit_o, 1'b0);
    tick();
    chk("snoop_push_accepted", s_acc, 1'b1);
    evict_valid_i = 1'b0;
    chk("snoop_hit_after_push", snoop_hit_o, 1'b1);
    b_valid_i = 1'b1;
    wait_b();
    snoop_addr_i = 64'h8000_0040;
    #1;
    chk("snoop_miss_after_b", snoop_hit_o, 1'b0);
    snoop_addr_i = 64'h8000_0080;
    #1;
    chk("snoop_other_still_held", snoop_hit_o, 1'b1);
    wait_idle();
    snoop_addr_i = 64'h0;

    // Error response: one-cycle err pulse, entry still freed.
    b_resp_i = 2'b10;
    do_push(64'h8000_5000, {64'h5001, 64'h5000});
    wait_b();
    chk("err_pulse", err_o, 1'b1);
    chk("err_entry_freed", busy_o, 1'b0);
    chk("err_ready", evict_ready_o, 1'b1);
    b_resp_i = 2'b00;
    tick();
    chk("err_one_cycle", err_o, 1'b0);
    wait_idle();

    // Reset in SEND_W after beat 0.
    b_valid_i = 1'b0;
    do_push(64'h8000_6000, {64'h6001, 64'h6000});
    tick();
    tick();
    chk("mid_burst_beat1", w_last_o, 1'b1);
    w_ready_i    = 1'b0;
    rst_ni       = 1'b0;
    snoop_addr_i = 64'h8000_6000;
    tick();
    chk("mrst_evict_ready", evict_ready_o, 1'b1);
    chk("mrst_aw_valid", aw_valid_o, 1'b0);
    chk("mrst_w_valid", w_valid_o, 1'b0);
    chk("mrst_b_ready", b_ready_o, 1'b0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_err", err_o, 1'b0);
    chk("mrst_snoop", snoop_hit_o, 1'b0);
    chk("mrst_abandoned_beats", exp_w.size(), 1);
    exp_w.delete();
    rst_ni    = 1'b1;
    w_ready_i = 1'b1;
    b_valid_i = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_aw_idle", aw_valid_o, 1'b0);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_aw_queue", exp_aw.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
